// File: rtl/bc_pkg.sv
// bc_pkg: shared types and defaults for the basic-computer memory arbiter.
package bc_pkg;
    localparam int BC_AW       = 12;
    localparam int BC_DW       = 16;
    localparam int MEM_LAT_MAX = 7;
    localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
    typedef enum logic {ID_CPU, ID_IO} req_id_t;

    function automatic req_id_t other_id(req_id_t id);
        return (id == ID_CPU) ? ID_IO : ID_CPU;
    endfunction
endpackage

// File: rtl/bc_mem_arbiter_if.sv
// bc_mem_arbiter_if: CPU port, IO/DMA port and memory-side bus of the arbiter.
interface bc_mem_arbiter_if #(parameter int AW = 12, parameter int DW = 16);
    logic          cpu_req, cpu_we, cpu_gnt, cpu_done;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          io_req, io_we, io_gnt, io_done;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata, io_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, io_req, io_we, io_addr, io_wdata, mem_rdata,
        output cpu_gnt, cpu_done, cpu_rdata, io_gnt, io_done, io_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, io_req, io_we, io_addr, io_wdata, mem_rdata,
        input  cpu_gnt, cpu_done, cpu_rdata, io_gnt, io_done, io_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/bc_arb_pick.sv
// bc_arb_pick: combinational CPU/IO winner select.
// ARB_RR_EN defined: ties go to the favoured port; otherwise IO always wins ties.
module bc_arb_pick
    import bc_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_fav,
    output req_id_t    o_id,
    output logic       o_valid
);
    assign o_valid = |i_req;
`ifdef ARB_RR_EN
    assign o_id = (&i_req) ? i_fav : (i_req[ID_IO] ? ID_IO : ID_CPU);
`else
    logic w_unused;
    assign w_unused = i_fav;
    assign o_id = i_req[ID_IO] ? ID_IO : ID_CPU;
`endif
endmodule

// File: rtl/bc_mem_arbiter.sv
// bc_mem_arbiter: serialises CPU and IO/DMA accesses onto the single-port main memory.
// Tie policy selected by ARB_RR_EN (round-robin) or fixed IO priority when undefined.
module bc_mem_arbiter
    import bc_pkg::*;
#(
    parameter int AW      = BC_AW,
    parameter int DW      = BC_DW,
    parameter int MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    bc_mem_arbiter_if.slave   io_bus
);
    arb_state_t       r_state, w_next;
    req_id_t          r_id, r_fav, w_id;
    logic             w_valid, w_take, r_we, w_acc, w_resp;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata, r_cpu_rdata, r_io_rdata;
    logic [CNT_W-1:0] r_cnt;

    bc_arb_pick u_pick (
        .i_req   ({io_bus.io_req, io_bus.cpu_req}),
        .i_fav   (r_fav),
        .o_id    (w_id),
        .o_valid (w_valid)
    );

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        case (r_state)
            IDLE: begin
                w_take = w_valid;
                w_next = w_valid ? ACCESS : IDLE;
            end
            ACCESS: w_next = WAIT;
            WAIT:   w_next = (r_cnt == '0) ? RESP : WAIT;
            RESP: begin
                w_take = w_valid;
                w_next = w_valid ? ACCESS : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_id        <= ID_CPU;
            r_fav       <= ID_IO;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_id    <= w_id;
                r_fav   <= other_id(w_id);
                r_we    <= (w_id == ID_IO) ? io_bus.io_we    : io_bus.cpu_we;
                r_addr  <= (w_id == ID_IO) ? io_bus.io_addr  : io_bus.cpu_addr;
                r_wdata <= (w_id == ID_IO) ? io_bus.io_wdata : io_bus.cpu_wdata;
            end
            if (r_state == ACCESS)
                r_cnt <= CNT_W'(MEM_LAT - 1);
            else if (r_state == WAIT && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            // read data lands on the last WAIT cycle and stays on the port until its next read
            if (r_state == WAIT && r_cnt == '0 && !r_we) begin
                if (r_id == ID_IO)
                    r_io_rdata <= io_bus.mem_rdata;
                else
                    r_cpu_rdata <= io_bus.mem_rdata;
            end
        end
    end

    assign w_acc  = (r_state == ACCESS);
    assign w_resp = (r_state == RESP);

    assign io_bus.mem_en    = w_acc;
    assign io_bus.mem_we    = w_acc & r_we;
    assign io_bus.mem_addr  = w_acc ? r_addr : '0;
    assign io_bus.mem_wdata = (w_acc & r_we) ? r_wdata : '0;
    assign io_bus.cpu_gnt   = w_acc  && (r_id == ID_CPU);
    assign io_bus.io_gnt    = w_acc  && (r_id == ID_IO);
    assign io_bus.cpu_done  = w_resp && (r_id == ID_CPU);
    assign io_bus.io_done   = w_resp && (r_id == ID_IO);
    assign io_bus.cpu_rdata = r_cpu_rdata;
    assign io_bus.io_rdata  = r_io_rdata;
    assign io_bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_bc_mem_arbiter.sv
// tb_bc_mem_arbiter: directed tests with a cycle-level transaction model checking dut0 (MEM_LAT=1)
// every cycle; dut1 (MEM_LAT=3) is checked against hand-computed timing.
module tb_bc_mem_arbiter;
    import bc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bc_mem_arbiter_if #(.AW(12), .DW(16)) b0 ();
    bc_mem_arbiter_if #(.AW(12), .DW(16)) b1 ();

    bc_mem_arbiter #(.MEM_LAT(1)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b0));
    bc_mem_arbiter #(.MEM_LAT(3)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b1));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // memories: data is only valid exactly MEM_LAT cycles after mem_en, garbage otherwise
    logic [15:0] m0 [4096];
    logic [15:0] m1 [4096];
    logic        v0 = 1'b0;
    logic [15:0] d0;
    logic [2:0]  v1 = 3'b0;
    logic [15:0] d1 [3];

    always @(posedge clk) begin
        if (!rst_n) begin
            m0[12'h600] <= 16'h7653;
            m1[12'h600] <= 16'h7653;
        end else begin
            if (b0.mem_en && b0.mem_we) m0[b0.mem_addr] <= b0.mem_wdata;
            if (b1.mem_en && b1.mem_we) m1[b1.mem_addr] <= b1.mem_wdata;
        end
        v0    <= b0.mem_en;
        d0    <= m0[b0.mem_addr];
        v1    <= {v1[1:0], b1.mem_en};
        d1[0] <= m1[b1.mem_addr];
        d1[1] <= d1[0];
        d1[2] <= d1[1];
    end

    assign b0.mem_rdata = v0    ? d0    : 16'hBAD0;
    assign b1.mem_rdata = v1[2] ? d1[2] : 16'hBAD0;

    // transaction model for dut0: one access at a time, done 1+MEM_LAT cycles after grant
    logic [15:0] mm [4096];
    logic [15:0] exp_rd [2];
    logic [11:0] p_addr [2];
    logic [15:0] p_wd [2];
    logic [1:0]  p_req = 2'b0, p_we = 2'b0;
    logic        arb_ok = 1'b0, fwe = 1'b0;
    logic [11:0] faddr = '0;
    int          cyc = 0, done_at = -1, fav = 1, fid = 0;

    always @(negedge clk) begin : model
        int w;
        logic [1:0] eg, ed;
        cyc++;
        if (!rst_n) begin
            chk("rst_outs", {b0.cpu_gnt, b0.io_gnt, b0.cpu_done, b0.io_done, b0.mem_en, b0.mem_we, b0.busy}, 0);
            chk("rst_rdata", {b0.cpu_rdata, b0.io_rdata}, 0);
            done_at = -1;
            arb_ok = 1'b0;
            fav = 1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            mm[12'h600] = 16'h7653;
        end else begin
            eg = 2'b0;
            ed = 2'b0;
            if (arb_ok && p_req != 2'b0) begin
`ifdef ARB_RR_EN
                w = (p_req == 2'b11) ? fav : (p_req[1] ? 1 : 0);
`else
                w = p_req[1] ? 1 : 0;
`endif
                eg[w] = 1'b1;
                fav = 1 - w;
                fid = w;
                fwe = p_we[w];
                faddr = p_addr[w];
                done_at = cyc + 2;
                chk("mem_addr", b0.mem_addr, faddr);
                chk("mem_we", b0.mem_we, fwe);
                if (fwe) begin
                    chk("mem_wdata", b0.mem_wdata, p_wd[w]);
                    mm[faddr] = p_wd[w];
                end
            end
            if (cyc == done_at) begin
                ed[fid] = 1'b1;
                if (!fwe) exp_rd[fid] = mm[faddr];
            end
            chk("gnt", {b0.io_gnt, b0.cpu_gnt}, eg);
            chk("mem_en", b0.mem_en, |eg);
            chk("done", {b0.io_done, b0.cpu_done}, ed);
            chk("cpu_rdata", b0.cpu_rdata, exp_rd[0]);
            chk("io_rdata", b0.io_rdata, exp_rd[1]);
            chk("busy", b0.busy, done_at >= cyc);
            arb_ok = (done_at <= cyc);
            p_req = {b0.io_req, b0.cpu_req};
            p_we = {b0.io_we, b0.cpu_we};
            p_addr[0] = b0.cpu_addr;
            p_addr[1] = b0.io_addr;
            p_wd[0] = b0.cpu_wdata;
            p_wd[1] = b0.io_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] who;
        int n;
        {b0.cpu_req, b0.cpu_we, b0.io_req, b0.io_we} = '0;
        {b1.cpu_req, b1.cpu_we, b1.io_req, b1.io_we} = '0;
        b0.cpu_addr = '0; b0.io_addr = '0; b0.cpu_wdata = '0; b0.io_wdata = '0;
        b1.cpu_addr = '0; b1.io_addr = '0; b1.cpu_wdata = '0; b1.io_wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_busy", b0.busy, 0);

        // CPU read alone
        b0.cpu_req = 1'b1; b0.cpu_addr = 12'h600;
        step();
        chk("t1_gnt", b0.cpu_gnt, 1);
        chk("t1_mem_en", b0.mem_en, 1);
        chk("t1_addr", b0.mem_addr, 12'h600);
        b0.cpu_req = 1'b0;
        step();
        chk("t1_c2_done", b0.cpu_done, 0);
        step();
        chk("t1_done", b0.cpu_done, 1);
        chk("t1_rdata", b0.cpu_rdata, 16'h7653);
        step();
        chk("t1_idle", b0.busy, 0);

        // IO write then CPU read-back, CPU request raised in the IO done cycle
        b0.io_req = 1'b1; b0.io_we = 1'b1; b0.io_addr = 12'h700; b0.io_wdata = 16'h7439;
        step();
        chk("t2_io_gnt", b0.io_gnt, 1);
        chk("t2_mem_we", b0.mem_we, 1);
        chk("t2_wdata", b0.mem_wdata, 16'h7439);
        b0.io_req = 1'b0; b0.io_we = 1'b0;
        step();
        step();
        chk("t2_io_done", b0.io_done, 1);
        chk("t2_io_rdata", b0.io_rdata, 0);
        b0.cpu_req = 1'b1; b0.cpu_addr = 12'h700;
        step();
        chk("t2_cpu_gnt", b0.cpu_gnt, 1);
        chk("t2_rd_we", b0.mem_we, 0);
        b0.cpu_req = 1'b0;
        step();
        step();
        chk("t2_cpu_done", b0.cpu_done, 1);
        chk("t2_rdata", b0.cpu_rdata, 16'h7439);
        step();

        // both ports request continuously
        b0.cpu_req = 1'b1; b0.cpu_addr = 12'h700;
        b0.io_req = 1'b1; b0.io_addr = 12'h600;
        who = '0;
        n = 0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            step();
            if (b0.io_gnt) begin who[n] = 1'b1; n++; end
            else if (b0.cpu_gnt) begin who[n] = 1'b0; n++; end
        end
        b0.cpu_req = 1'b0; b0.io_req = 1'b0;
        chk("t3_count", n, 6);
`ifdef ARB_RR_EN
        chk("t3_seq", who, 6'b010101);
`else
        chk("t3_seq", who, 6'b111111);
`endif
        repeat (4) step();

        // CPU holds req through done: regranted straight from RESP
        b0.cpu_req = 1'b1; b0.cpu_addr = 12'h600;
        step();
        chk("t6_gnt1", b0.cpu_gnt, 1);
        step();
        chk("t6_c2_gnt", b0.cpu_gnt, 0);
        step();
        chk("t6_done", {b0.cpu_done, b0.cpu_gnt}, 2'b10);
        step();
        chk("t6_gnt2", b0.cpu_gnt, 1);
        b0.cpu_req = 1'b0;
        repeat (4) step();

        // reset during WAIT of an IO read
        b0.io_req = 1'b1; b0.io_addr = 12'h600;
        step();
        chk("t5_io_gnt", b0.io_gnt, 1);
        b0.io_req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", {b0.io_gnt, b0.io_done, b0.mem_en, b0.busy, b0.cpu_gnt, b0.cpu_done}, 0);
        chk("t5_rst_rdata", {b0.cpu_rdata, b0.io_rdata}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_no_io_done", b0.io_done, 0);
        end
        b0.cpu_req = 1'b1; b0.cpu_addr = 12'h600;
        step();
        chk("t5_cpu_gnt", b0.cpu_gnt, 1);
        b0.cpu_req = 1'b0;
        step();
        step();
        chk("t5_cpu_done", b0.cpu_done, 1);
        chk("t5_cpu_rdata", b0.cpu_rdata, 16'h7653);
        step();

        // MEM_LAT=3 CPU read on dut1
        b1.cpu_req = 1'b1; b1.cpu_addr = 12'h600;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk("t4_mem_en", b1.mem_en, c == 1);
            chk("t4_busy", b1.busy, c <= 5);
            chk("t4_done", b1.cpu_done, c == 5);
            if (c == 1) b1.cpu_req = 1'b0;
            if (c == 5) chk("t4_rdata", b1.cpu_rdata, 16'h7653);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
